k580vt57_dma: RTL
=================

// Module: k580vt57_dma
// PURPOSE
//  4-channel DMA controller, functionally i8257/KR580VT57. Runs on one clock.
//  Channel 2 fetches screen/attribute bytes from RAM in read mode (memr_n + iow_n) and
//  presents them to the CRT controller's dack/ichar pair. Raises hrq to the CPU;
//  once hlda is granted, it runs one byte transfer per request.
// PARAMETERS
//  none
// PORTS
//  clk      in   1   system clock; all logic on posedge
//  reset    in   1   synchronous, active-high
//  ce       in   1   DMA state advance enable (1 pulse per DMA clock)
//  iaddr    in   4   CPU register address
//  idata    in   8   CPU write data
//  odata    out  8   CPU read data (combinational)
//  iwe_n    in   1   CPU write strobe; acts on falling edge
//  ird_n    in   1   CPU read strobe; side effects on rising edge
//  hlda     in   1   bus grant from CPU
//  hrq      out  1   bus request to CPU
//  drq      in   4   channel requests (bit n = channel n)
//  dack     out  4   channel acknowledges, one-hot or zero
//  oaddr    out  16  memory address during transfer
//  memr_n   out  1   memory read strobe
//  memw_n   out  1   memory write strobe
//  ior_n    out  1   I/O read strobe (device to memory)
//  iow_n    out  1   I/O write strobe (memory to device)
//  tc       out  1   terminal count, high in S3..S4 of last byte
// BEHAVIOUR
//  Reset: hrq=0, dack=0, all strobes=1, oaddr=0, tc=0, mode=0, byte flip-flop=0,
//   status=0, state=SI. The address/count registers are not reset.
//  Registers: iaddr[3]=0 -> channel iaddr[2:1], iaddr[0]=0 address, =1 count.
//   Count[13:0] = N-1 transfers; count[15:14] = 00 verify, 01 write (ior+memw),
//   10 read (memr+iow), 11 illegal (treated as verify).
//   Each access to a channel register (read or write) toggles the flip-flop:
//   0 = low byte, 1 = high byte.
//  Address 8 write = mode: [3:0] channel enable, [4] rotating priority,
//   [5] extended write, [6] TC stop, [7] autoload. A mode write clears the flip-flop.
//  Address 8 read = status: [3:0] TC flags, [4] update flag.
//   The TC flags clear on the ird_n rising edge. Addresses 9..15 read 0; writes ignored.
//  FSM, advancing only when ce=1:
//   SI: if any enabled channel has drq -> S0, hrq=1.
//   S0: wait for hlda=1. Latch the winning channel -> S1.
//   S1: dack[ch]=1, oaddr=addr[ch] -> S2.
//   S2: assert the read strobe (memr_n or ior_n). If extended write is set, also
//       assert the write strobe -> S3.
//   S3: assert the write strobe. tc=1 if count[13:0]==0 -> S4.
//   S4: release strobes and dack. Then: addr+=1 (16-bit wrap FFFF->0000);
//       count[13:0]-=1 (wraps to 3FFF, not an error).
//       On TC: set status TC[ch]; if TC stop is set, clear enable[ch].
//       Next state: if any enabled drq and hlda is still 1 -> S1; else hrq=0 -> SI.
//  Priority: fixed, ch0 highest. With rotating priority, the serviced channel
//   becomes lowest after S4.
//  drq falling mid-cycle: the cycle completes; no new cycle starts for that channel.
//  hlda falling in S1..S3: the cycle completes, then the FSM goes to SI with hrq=0.
//  CPU writes to the active channel's registers during S1..S4 are ignored;
//   the flip-flop still toggles.
//  Register write and S4 update on the same clock: the S4 update wins.
//  Verify mode: no memory/IO strobes; dack and tc are asserted as normal.
//  reset mid-transfer: all outputs return to reset values on the next clock.
// CONFIGURATION
//  K580VT57_AUTOLOAD_EN defined:
//   - When mode[7]=1 and channel 2 reaches TC, S4 copies ch3 address and count
//     into ch2 and sets update flag.
//   - Channel 2 stays enabled, even if TC stop is set.
//   - The update flag clears on the next status read.
//   - CPU writes to ch2 registers while mode[7]=1 also load ch3.
//  Not defined: mode[7] is stored and reads back, but has no effect.
//   The update flag always reads 0.
// TESTING
//  1 Write ch2 addr=0x76D0, count=0x804D, mode=0x04; pulse drq[2]; hlda=1
//    -> 78 cycles; each has memr_n and iow_n low. oaddr runs 76D0..771D.
//    tc=1 on the cycle at 771D only; status reads 0x04, then 0x00.
//  2 Byte flip-flop: write 0x34, 0x12 to address 0, then read address 0 twice
//    -> 0x34, 0x12. Mode write mid-sequence resets the order.
//  3 drq[0] and drq[2] both high, fixed priority -> ch0 served first.
//    With mode[4]=1 and both held high -> service alternates 0,2,0,2.
//  4 ch1 addr=0xFFFF, count=0x4001 -> oaddr FFFF then 0000; both cycles show
//    ior_n and memw_n low.
//  5 reset=1 during S2 -> on the next clock hrq=0, dack=0, strobes=1, tc=0.
//    A new request after reset completes normally.
//  6 Macro on, mode=0xC4, ch3 count=0x8001 -> after ch2 TC, ch2 reloads;
//    ch2 stays enabled; status bit4=1.

Source files
------------

// File: rtl/k580vt57_dma_if.sv
// CPU register port and DMA bus handshake of the K580VT57 controller.
interface k580vt57_dma_if;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic        hlda;
  logic        hrq;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic [15:0] oaddr;
  logic        memr_n;
  logic        memw_n;
  logic        ior_n;
  logic        iow_n;
  logic        tc;

  modport master (
    input  iaddr, idata, iwe_n, ird_n, hlda, drq,
    output odata, hrq, dack, oaddr, memr_n, memw_n, ior_n, iow_n, tc
  );

  modport slave (
    output iaddr, idata, iwe_n, ird_n, hlda, drq,
    input  odata, hrq, dack, oaddr, memr_n, memw_n, ior_n, iow_n, tc
  );
endinterface

// File: rtl/k580vt57_dma.sv
// 4-channel i8257-compatible DMA controller (SI/S0..S4 cycle engine, CPU register file).
// Optional ch3->ch2 autoload is built when K580VT57_AUTOLOAD_EN is defined.
module k580vt57_dma (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  k580vt57_dma_if.master bus
);
  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t           state, state_nx;
  logic [3:0][15:0] addr, cnt;
  logic [7:0]       mode;
  logic             ff, upd, iwe_q, ird_q;
  logic [3:0]       tc_stat, req, clr;
  logic [1:0]       ch, ch_nx, last, start, sel;
  logic             wr_stb, rd_stb, active, tc_now, al, mirror;
  logic             rdm, wrm, rd_on, wr_on;
  logic [15:0]      rsel;

  assign wr_stb = iwe_q & ~bus.iwe_n;
  assign rd_stb = ~ird_q & bus.ird_n;
  assign sel    = bus.iaddr[2:1];
  assign active = (state == S1) || (state == S2) || (state == S3) || (state == S4);
  assign tc_now = (cnt[ch][13:0] == 14'd0);
`ifdef K580VT57_AUTOLOAD_EN
  assign al     = mode[7] && (ch == 2'd2);
  assign mirror = mode[7] && (sel == 2'd2);
`else
  assign al     = 1'b0;
  assign mirror = 1'b0;
`endif

  // Request set seen by the arbiter already excludes a channel that TC-stop is
  // about to disable, so S4 never chains back into it.
  assign clr   = (state == S4 && tc_now && mode[6] && !al) ? (4'b0001 << ch) : 4'b0000;
  assign req   = bus.drq & mode[3:0] & ~clr;
  assign start = mode[4] ? (((state == S4) ? ch : last) + 2'd1) : 2'd0;

  always_comb begin
    logic       found;
    logic [1:0] idx;
    ch_nx = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && req[idx]) begin
        ch_nx = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (ce) begin
      case (state)
        SI: if (|req) state_nx = S0;
        S0: if (bus.hlda) state_nx = (|req) ? S1 : SI;
        S1: state_nx = S2;
        S2: state_nx = S3;
        S3: state_nx = S4;
        S4: state_nx = (|req && bus.hlda) ? S1 : SI;
        default: state_nx = SI;
      endcase
    end
  end

  assign rdm   = (cnt[ch][15:14] == 2'b10);
  assign wrm   = (cnt[ch][15:14] == 2'b01);
  assign rd_on = (state == S2) || (state == S3);
  assign wr_on = (state == S3) || (state == S2 && mode[5]);

  assign bus.hrq    = (state != SI);
  assign bus.dack   = (state == S1 || state == S2 || state == S3) ? (4'b0001 << ch) : 4'b0000;
  assign bus.oaddr  = active ? addr[ch] : 16'h0000;
  assign bus.memr_n = ~(rdm & rd_on);
  assign bus.iow_n  = ~(rdm & wr_on);
  assign bus.ior_n  = ~(wrm & rd_on);
  assign bus.memw_n = ~(wrm & wr_on);
  assign bus.tc     = ((state == S3) || (state == S4)) && tc_now;

  assign rsel = bus.iaddr[0] ? cnt[sel] : addr[sel];
  always_comb begin
    bus.odata = 8'h00;
    if (!bus.iaddr[3])         bus.odata = ff ? rsel[15:8] : rsel[7:0];
    else if (bus.iaddr == 4'd8) bus.odata = {3'b000, upd, tc_stat};
  end

  // Address/count registers deliberately have no reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SI;
      mode    <= 8'h00;
      ff      <= 1'b0;
      tc_stat <= 4'h0;
      upd     <= 1'b0;
      ch      <= 2'd0;
      last    <= 2'd3;
      iwe_q   <= 1'b1;
      ird_q   <= 1'b1;
    end else begin
      iwe_q <= bus.iwe_n;
      ird_q <= bus.ird_n;
      state <= state_nx;
      if ((state == S0 || state == S4) && state_nx == S1) ch <= ch_nx;

      if (wr_stb) begin
        if (!bus.iaddr[3]) begin
          ff <= ~ff;
          for (int j = 0; j < 4; j++) begin
            if ((sel == j[1:0] || (mirror && j == 3)) && !(active && ch == j[1:0])) begin
              if (bus.iaddr[0]) begin
                if (ff) cnt[j][15:8] <= bus.idata;
                else    cnt[j][7:0]  <= bus.idata;
              end else begin
                if (ff) addr[j][15:8] <= bus.idata;
                else    addr[j][7:0]  <= bus.idata;
              end
            end
          end
        end else if (bus.iaddr == 4'd8) begin
          mode <= bus.idata;
          ff   <= 1'b0;
        end
      end

      if (rd_stb) begin
        if (!bus.iaddr[3]) ff <= ~ff;
        else if (bus.iaddr == 4'd8) begin
          tc_stat <= 4'h0;
          upd     <= 1'b0;
        end
      end

      // End-of-cycle update sits last so it overrides a same-clock CPU write.
      if (ce && state == S4) begin
        last <= ch;
        if (al && tc_now) begin
          addr[2] <= addr[3];
          cnt[2]  <= cnt[3];
          upd     <= 1'b1;
        end else begin
          addr[ch]       <= addr[ch] + 16'd1;
          cnt[ch][13:0]  <= cnt[ch][13:0] - 14'd1;
        end
        if (tc_now) begin
          tc_stat[ch] <= 1'b1;
          if (mode[6] && !al) mode[ch] <= 1'b0;
        end
      end
    end
  end
endmodule
